// File: rtl/gry_to_bin_pkg.sv
// Shared constants and the reference Gray-to-binary decode for the gray_to_bin block.
// Used by the RTL datapath and by the testbench scoreboard alike.
package gry_to_bin_pkg;

  localparam int GRY_TO_BIN_MAX_WID = 32;

  // Bits at or above w are forced to zero so callers may pass a zero-extended word.
  function automatic logic [GRY_TO_BIN_MAX_WID-1:0] gray2bin(
    input logic [GRY_TO_BIN_MAX_WID-1:0] g,
    input int                            w
  );
    logic [GRY_TO_BIN_MAX_WID-1:0] b;
    logic                          acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GRY_TO_BIN_MAX_WID - 1; i >= 0; i--) begin
      if (i < w) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/gry_to_bin_comb.sv
// Pure combinational Gray-to-binary ripple chain, width set by wid (1..32).
// No state; the enclosing block registers the result.
module gry_to_bin_comb
  import gry_to_bin_pkg::*;
#(
  parameter int wid = 4
) (
  input  logic [wid-1:0] gry,
  output logic [wid-1:0] bin
);

  logic [GRY_TO_BIN_MAX_WID-1:0] gry_ext;
  logic [GRY_TO_BIN_MAX_WID-1:0] bin_ext;
  logic                          unused_hi;

  assign gry_ext = GRY_TO_BIN_MAX_WID'(gry);
  assign bin_ext = gray2bin(gry_ext, wid);
  assign bin     = bin_ext[wid-1:0];

  // Upper bits of the full-width decode are always zero for narrow instances.
  assign unused_hi = ^bin_ext;

endmodule

// File: rtl/gray_to_bin.sv
// Registered Gray-to-binary converter with a one-cycle valid pipeline.
// Define GRY_TO_BIN_STEP_CHECK_EN to add step_err, flagging multi-bit Gray steps.
module gray_to_bin
  import gry_to_bin_pkg::*;
#(
  parameter int wid = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [wid-1:0] Gry,
  input  logic           in_valid,
  output logic [wid-1:0] Bin,
`ifdef GRY_TO_BIN_STEP_CHECK_EN
  output logic           step_err,
`endif
  output logic           out_valid
);

  logic [wid-1:0] bin_next;

  gry_to_bin_comb #(
    .wid(wid)
  ) u_comb (
    .gry(Gry),
    .bin(bin_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Bin       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Bin <= bin_next;
      end
    end
  end

`ifdef GRY_TO_BIN_STEP_CHECK_EN
  logic [wid-1:0] prev_gry;
  logic [wid-1:0] step_diff;
  logic           have_prev;
  logic           multi_bit;

  // x & (x-1) clears the lowest set bit, so a nonzero result means two or more bits changed.
  assign step_diff = Gry ^ prev_gry;
  assign multi_bit = (step_diff & (step_diff - wid'(1))) != '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_gry  <= '0;
      have_prev <= 1'b0;
      step_err  <= 1'b0;
    end else begin
      step_err <= 1'b0;
      if (in_valid) begin
        step_err  <= have_prev & multi_bit;
        prev_gry  <= Gry;
        have_prev <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_to_bin.sv
// Directed bench for gray_to_bin: 3-bit and 4-bit instances, holds, async reset.
// Step-error expectations are active when GRY_TO_BIN_STEP_CHECK_EN is defined.
module tb_gray_to_bin;
  import gry_to_bin_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gry4, bin4;
  logic       vin4, vout4;
  logic [2:0] gry3, bin3;
  logic       vin3, vout3;
`ifdef GRY_TO_BIN_STEP_CHECK_EN
  logic       serr4, serr3;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gray_to_bin #(.wid(4)) dut4 (
    .clk(clk), .rst(rst), .Gry(gry4), .in_valid(vin4), .Bin(bin4),
`ifdef GRY_TO_BIN_STEP_CHECK_EN
    .step_err(serr4),
`endif
    .out_valid(vout4)
  );

  gray_to_bin #(.wid(3)) dut3 (
    .clk(clk), .rst(rst), .Gry(gry3), .in_valid(vin3), .Bin(bin3),
`ifdef GRY_TO_BIN_STEP_CHECK_EN
    .step_err(serr3),
`endif
    .out_valid(vout3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] g4, input logic v4, input logic [2:0] g3, input logic v3);
    @(negedge clk);
    gry4 = g4; vin4 = v4; gry3 = g3; vin3 = v3;
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] eb, input logic ev, input logic ee);
    checkOutput({tag, "_bin4"}, 32'(bin4), 32'(eb));
    checkOutput({tag, "_vld4"}, 32'(vout4), 32'(ev));
`ifdef GRY_TO_BIN_STEP_CHECK_EN
    checkOutput({tag, "_err4"}, 32'(serr4), 32'(ee));
`else
    if (ee === 1'bx) $display("[TB] note: unknown step expectation in %s", tag);
`endif
  endtask

  logic [2:0] g3_tab [8]  = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic [3:0] g4_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0]  prev4, r4;
    logic [31:0] model;

    rst = 1'b1; gry4 = '0; vin4 = 1'b0; gry3 = '0; vin3 = 1'b0;
    #12;
    check4("reset", 4'h0, 1'b0, 1'b0);
    checkOutput("reset_bin3", 32'(bin3), 32'h0);
    checkOutput("reset_vld3", 32'(vout3), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 3-bit sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'h0, 1'b0, g3_tab[i], 1'b1);
      checkOutput($sformatf("sweep3_%0d_bin", i), 32'(bin3), 32'(i));
      checkOutput($sformatf("sweep3_%0d_vld", i), 32'(vout3), 32'h1);
`ifdef GRY_TO_BIN_STEP_CHECK_EN
      checkOutput($sformatf("sweep3_%0d_err", i), 32'(serr3), 32'h0);
`endif
    end

    // 4-bit sweep, back-to-back; all single-bit steps
    for (int i = 0; i < 16; i++) begin
      applyStimulus(g4_tab[i], 1'b1, 3'b000, 1'b0);
      check4($sformatf("sweep4_%0d", i), 4'(i), 1'b1, 1'b0);
    end
    checkOutput("sweep3_idle_vld", 32'(vout3), 32'h0);

    applyStimulus(4'b0000, 1'b1, 3'b000, 1'b0);
    check4("wrap", 4'b0000, 1'b1, 1'b0);

    applyStimulus(4'b1100, 1'b1, 3'b000, 1'b0);
    check4("pre_hold", 4'b1000, 1'b1, 1'b1);
    applyStimulus(4'b1111, 1'b0, 3'b000, 1'b0);
    check4("hold1", 4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 3'b000, 1'b0);
    check4("hold2", 4'b1000, 1'b0, 1'b0);
    applyStimulus(4'b0110, 1'b1, 3'b000, 1'b0);
    check4("after_hold", 4'b0100, 1'b1, 1'b1);

    applyStimulus(4'b0001, 1'b1, 3'b000, 1'b0);
    check4("step_a", 4'b0001, 1'b1, 1'b1);
    applyStimulus(4'b0011, 1'b1, 3'b000, 1'b0);
    check4("step_b", 4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0010, 1'b1, 3'b000, 1'b0);
    check4("step_c", 4'b0011, 1'b1, 1'b0);
    applyStimulus(4'b1101, 1'b1, 3'b000, 1'b0);
    check4("step_jump", 4'b1001, 1'b1, 1'b1);
    applyStimulus(4'b1000, 1'b1, 3'b000, 1'b0);
    check4("step_d", 4'b1111, 1'b1, 1'b1);
    applyStimulus(4'b0000, 1'b1, 3'b000, 1'b0);
    check4("step_wrap", 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 3'b000, 1'b0);
    check4("step_clear", 4'b0000, 1'b0, 1'b0);

    // Pseudo-random valid stream checked against the package model
    prev4 = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      r4 = 4'($urandom_range(0, 15));
      model = gray2bin(32'(r4), 4);
      applyStimulus(r4, 1'b1, 3'b000, 1'b0);
      check4($sformatf("rand_%0d", i), model[3:0], 1'b1, $countones(r4 ^ prev4) > 1);
      prev4 = r4;
    end

    // Asynchronous reset in the middle of a conversion
    applyStimulus(4'b1101, 1'b1, 3'b101, 1'b1);
    check4("pre_rst", 4'b1001, 1'b1, $countones(4'b1101 ^ prev4) > 1);
    checkOutput("pre_rst_bin3", 32'(bin3), 32'h6);
    #2;
    rst = 1'b1;
    #1;
    check4("async_rst", 4'b0000, 1'b0, 1'b0);
    checkOutput("async_rst_bin3", 32'(bin3), 32'h0);
    checkOutput("async_rst_vld3", 32'(vout3), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b1101, 1'b1, 3'b000, 1'b0);
    check4("post_rst", 4'b1001, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
